// File: rtl/shift_unit_arbiter.sv
// Shared 32-bit right barrel shifter with round-robin access from NUM_REQ requesters.
// SLL is produced by bit-reversing the operand around the right shifter.
// One operation is in flight at a time: IDLE (grant/capture) -> SHIFT -> RESP.
module shift_unit_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_data,
    input  logic [NUM_REQ*5-1:0]  req_amount,
    input  logic [NUM_REQ*2-1:0]  req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;

    state_t          state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] owner_q;
    logic [31:0]     data_q;
    logic [4:0]      amount_q;
    logic [1:0]      op_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_data_q;
    logic [ID_W-1:0] rsp_id_q;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] rr_ptr_d;

    // Per-requester operand slices, unpacked so the granted one can be picked by index.
    logic [31:0] data_arr   [NUM_REQ];
    logic [4:0]  amount_arr [NUM_REQ];
    logic [1:0]  op_arr     [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign data_arr[gi]   = req_data[32*gi +: 32];
            assign amount_arr[gi] = req_amount[5*gi +: 5];
            assign op_arr[gi]     = req_op[2*gi +: 2];
        end
    endgenerate

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        logic [ID_W:0] cand;
        grant_found = 1'b0;
        grant_idx   = rr_ptr_q;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Pointer moves to the requester just after the one granted, wrapping.
    always_comb begin
        logic [ID_W:0] nxt;
        nxt = {1'b0, grant_idx} + (ID_W+1)'(1);
        if (nxt >= (ID_W+1)'(NUM_REQ)) begin
            nxt = '0;
        end
        rr_ptr_d = nxt[ID_W-1:0];
    end

    // Accept is combinational and only possible while idle; never during reset.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_q == ST_IDLE) && !reset && grant_found
                                   && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Shifter datapath: optional reversal, five log stages, optional reversal back.
    logic        is_sll;
    logic        fill_bit;
    logic [31:0] operand_rev;
    logic [31:0] stage_rev;
    logic [31:0] shift_result;
    logic [31:0] stage [6];

    assign is_sll   = (op_q == OP_SLL);
    assign fill_bit = (op_q == OP_SRA) && data_q[31];

    generate
        for (gi = 0; gi < 32; gi++) begin : g_rev
            assign operand_rev[gi] = data_q[31-gi];
            assign stage_rev[gi]   = stage[5][31-gi];
        end
    endgenerate

    assign stage[0] = is_sll ? operand_rev : data_q;

    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = amount_q[gi] ? {{SH{fill_bit}}, stage[gi][31:SH]} : stage[gi];
        end
    endgenerate

    assign shift_result = is_sll ? stage_rev : stage[5];

    // Control FSM with operand capture and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            data_q      <= '0;
            amount_q    <= '0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        data_q   <= data_arr[grant_idx];
                        amount_q <= amount_arr[grant_idx];
                        op_q     <= op_arr[grant_idx];
                        owner_q  <= grant_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    rsp_data_q  <= shift_result;
                    rsp_id_q    <= owner_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule
